// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment pattern constants shared by the scan driver and nibble decoder.
// Patterns are active-high, ordered {A,B,C,D,E,F,G}.
package seven_seg_pkg;
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/seven_seg_nibble_decode.sv
// seven_seg_nibble_decode: combinational nibble to active-high segment pattern.
// With HEX_EN=0, nibbles 10-15 render blank.
module seven_seg_nibble_decode
  import seven_seg_pkg::*;
#(
  parameter int HEX_EN = 1
) (
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Seg
);
  logic [6:0] pat;
  always_comb begin
    case (i_Nibble)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
  end
  assign o_Seg = (HEX_EN == 0 && i_Nibble > 4'd9) ? SEG_BLANK : pat;
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit seven-segment driver with
// double-buffered loading, leading-zero blanking and a per-slot anti-ghost guard.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 4096,
  parameter int GUARD_CYCLES   = 16,
  parameter int HEX_EN         = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic                    i_Blank_Lz,
  output logic [6:0]              o_Segments,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Frame_Pulse
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW != 0 ? '1 : '0;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] pend_q, pend_d, shad_q, shad_d;
  logic pend_v_q, pend_v_d;
  logic [6:0] seg_q, seg_d, seg_hi, raw;
  logic [NUM_DIGITS-1:0] en_q, en_d, en_hi, lz;
  logic frame_q, tick, boundary, guard, run;
  logic [3:0] nib;
  assign tick     = presc_q == PW'(SCAN_DIV - 1);
  assign boundary = tick && idx_q == IW'(NUM_DIGITS - 1);
  assign guard    = presc_q < PW'(GUARD_CYCLES);
  assign nib      = shad_q[{idx_q, 2'b00} +: 4];
  seven_seg_nibble_decode #(.HEX_EN(HEX_EN)) u_dec (.i_Nibble(nib), .o_Seg(raw));
  // A boundary load goes straight to shadow so it is never lost behind pending.
  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = !tick ? idx_q : boundary ? '0 : idx_q + 1'b1;
    pend_d   = i_Load ? i_Value : pend_q;
    pend_v_d = boundary ? 1'b0 : (i_Load | pend_v_q);
    shad_d   = !boundary ? shad_q : i_Load ? i_Value : pend_v_q ? pend_q : shad_q;
  end
  // Digit k is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      run   = run & (shad_q[4*k +: 4] == 4'd0);
      lz[k] = run;
    end
  end
  always_comb begin
    seg_hi = (guard || (i_Blank_Lz && lz[idx_q])) ? SEG_BLANK : raw;
    en_hi  = guard ? '0 : NUM_DIGITS'(1) << idx_q;
    seg_d  = SEG_ACTIVE_LOW != 0 ? ~seg_hi : seg_hi;
    en_d   = DIG_ACTIVE_LOW != 0 ? ~en_hi : en_hi;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      presc_q  <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      shad_q   <= '0;
      seg_q    <= SEG_OFF;
      en_q     <= DIG_OFF;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      shad_q   <= shad_d;
      seg_q    <= seg_d;
      en_q     <= en_d;
      frame_q  <= boundary;
    end
  end
  assign o_Segments    = seg_q;
  assign o_Digit_En    = en_q;
  assign o_Frame_Pulse = frame_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: frame-synchronous directed stimulus with a slot-level scoreboard.
module tb_seven_seg_scan_driver;
  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101, P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011, P9 = 7'b1111011, PX = 7'b0000000;
  localparam logic [6:0] PA = 7'b1110111, PB = 7'b0011111, PC = 7'b1001110, PD = 7'b0111101;
  localparam logic [6:0] PF = 7'b1000111;
  localparam logic [5:0] NO = 6'd63;
  logic clk = 0, rst_n = 0, load = 0, blank = 0;
  logic [15:0] value = '0;
  logic [6:0] seg, segh;
  logic [3:0] en, enh;
  logic fp, fph;
  seven_seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .GUARD_CYCLES(2), .HEX_EN(1),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Load(load), .i_Value(value), .i_Blank_Lz(blank),
    .o_Segments(seg), .o_Digit_En(en), .o_Frame_Pulse(fp));
  seven_seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .GUARD_CYCLES(2), .HEX_EN(0),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_h (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Load(load), .i_Value(value), .i_Blank_Lz(blank),
    .o_Segments(segh), .o_Digit_En(enh), .o_Frame_Pulse(fph));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] en;
    logic [6:0] seg;
    logic [6:0] segh;
  } exp_t;
  typedef struct packed {
    logic           blank;
    logic [15:0]    v1;
    logic [5:0]     o1;
    logic [15:0]    v2;
    logic [5:0]     o2;
    logic           use_h;
    logic [3:0][6:0] e;
    logic [3:0][6:0] h;
  } frame_t;
  exp_t q[$];
  frame_t tbl[10];
  int checks = 0, errors = 0;
  bit armed = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  bit prev = 0;
  int run = 0;
  logic [3:0] en_hi;
  logic [6:0] seg_hi;
  exp_t x;
  always @(negedge clk) begin
    en_hi  = ~en;
    seg_hi = ~seg;
    if (!rst_n) begin
      prev = 0;
      run  = 0;
    end else if ((en_hi != 0) != prev) begin
      if (armed && prev) chk("lit_len", run, 6);
      if (armed && !prev) begin
        chk("guard_len", run, 2);
        if (q.size() == 0) chk("unexpected_slot", 0, 1);
        else begin
          x = q.pop_front();
          chk("digit_en", en_hi, x.en);
          chk("segments", seg_hi, x.seg);
          chk("hexoff_en", enh, x.en);
          chk("hexoff_seg", segh, x.segh);
        end
      end
      prev = en_hi != 0;
      run  = 1;
    end else run++;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{1'b0, 16'h1234, 6'd5,  16'h0000, NO,    1'b0, {P0, P0, P0, P0}, '0};
    tbl[1] = '{1'b0, 16'hABCD, 6'd20, 16'h0000, NO,    1'b0, {P1, P2, P3, P4}, '0};
    tbl[2] = '{1'b0, 16'h1111, 6'd3,  16'h2222, 6'd25, 1'b1, {PA, PB, PC, PD}, {PX, PX, PX, PX}};
    tbl[3] = '{1'b0, 16'h1111, 6'd5,  16'h0042, 6'd31, 1'b0, {P2, P2, P2, P2}, '0};
    tbl[4] = '{1'b0, 16'h0000, NO,    16'h0000, NO,    1'b0, {P0, P0, P4, P2}, '0};
    tbl[5] = '{1'b1, 16'h0000, 6'd10, 16'h0000, NO,    1'b0, {PX, PX, P4, P2}, '0};
    tbl[6] = '{1'b1, 16'h0400, 6'd10, 16'h0000, NO,    1'b0, {PX, PX, PX, P0}, '0};
    tbl[7] = '{1'b1, 16'h00F9, 6'd12, 16'h0000, NO,    1'b0, {PX, P4, P0, P0}, '0};
    tbl[8] = '{1'b1, 16'h0000, NO,    16'h0000, NO,    1'b1, {PX, PX, PF, P9}, {PX, PX, PX, P9}};
    tbl[9] = '{1'b0, 16'h0000, NO,    16'h0000, NO,    1'b1, {P0, P0, PF, P9}, {P0, P0, PX, P9}};
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (13) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("reset_seg", seg, 7'h7F);
    chk("reset_en", en, 4'hF);
    chk("reset_pulse", fp, 0);
    chk("reset_hexoff_en", enh, 0);
    repeat (2) @(negedge clk);
    chk("reset_hold_seg", seg, 7'h7F);
    chk("reset_hold_en", en, 4'hF);
    rst_n = 1;
    for (int i = 0; i < 100 && !fp; i++) @(negedge clk);
    chk("first_pulse", fp, 1);
    armed = 1;
    for (int f = 0; f < 10; f++) begin
      blank = tbl[f].blank;
      for (int d = 0; d < 4; d++)
        q.push_back('{4'(1 << d), tbl[f].e[d], tbl[f].use_h ? tbl[f].h[d] : tbl[f].e[d]});
      for (int c = 0; c < 32; c++) begin
        load  = (c == int'(tbl[f].o1)) || (c == int'(tbl[f].o2));
        value = (c == int'(tbl[f].o2)) ? tbl[f].v2 : tbl[f].v1;
        @(negedge clk);
        load = 0;
        if (c == 0) chk("pulse_width", fp, 0);
      end
      chk("frame_pulse", fp, 1);
    end
    armed = 0;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode or common-cathode seven-segment display. It holds a packed 4-bit-per-digit value and scans one digit per slot, enabling that digit and driving its segment pattern. It adds four things the single-digit decoder lacks: double-buffered tear-free loading, a hex/decimal mode, leading-zero blanking and an anti-ghosting guard interval. It sits between counter/datapath logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 4096, clock cycles per digit slot (>= GUARD_CYCLES+1, >= 2)
GUARD_CYCLES, 16, cycles at start of each slot with all digits disabled (0 = no guard)
HEX_EN, 1, 1: nibbles 10-15 show A b C d E F; 0: nibbles 10-15 show blank
SEG_ACTIVE_LOW, 0, 1: segment outputs inverted (lit = 0)
DIG_ACTIVE_LOW, 0, 1: digit enables inverted (enabled = 0)

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  reset, asynchronous, active-low
i_Load  in  1  single-cycle strobe; capture i_Value
i_Value  in  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (least significant, rightmost)
i_Blank_Lz  in  1  1: blank leading zero digits
o_Segments  out  7  [6]=A [5]=B [4]=C [3]=D [2]=E [1]=F [0]=G, registered
o_Digit_En  out  NUM_DIGITS  one-hot digit enable, registered
o_Frame_Pulse  out  1  one-cycle pulse at start of each full scan frame

Behaviour:
- Reset (async assert, sync release): prescaler=0, digit index=0, pending and shadow=0, pending-valid=0. o_Segments = all unlit and o_Digit_En = all disabled, both honouring the polarity params. o_Frame_Pulse=0. Reset mid-scan forces these values immediately.
- Prescaler counts 0..SCAN_DIV-1 and wraps. Slot tick is prescaler==SCAN_DIV-1. On a tick the index advances and wraps from NUM_DIGITS-1 to 0. The tick at wrap to 0 is the frame boundary.
- Load: i_Load=1 writes i_Value into pending and sets pending-valid. A second load before the boundary overwrites pending (latest wins).
- At the frame boundary, if pending-valid, shadow<=pending and pending-valid clears. If i_Load is high on the boundary cycle, shadow<=i_Value directly and pending-valid clears. Shadow never changes mid-frame.
- o_Frame_Pulse=1 in the cycle after the frame-boundary tick.
- Output register, updated every cycle from the current index, prescaler and shadow, giving 1-cycle latency:
  - prescaler < GUARD_CYCLES: all digits disabled; segments unlit.
  - otherwise: o_Digit_En has only bit[index] enabled. o_Segments = decode(shadow nibble[index]), or unlit if that digit is blanked.
- Decode (active-high, before polarity):
  0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  HEX_EN=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  HEX_EN=0: 10-15 = 0000000.
- Leading-zero blank: digit k is blanked when i_Blank_Lz=1 and nibbles k..NUM_DIGITS-1 of shadow are all 0. Digit 0 is never blanked, so value 0 shows a single "0". i_Blank_Lz is sampled live (not buffered).
- NUM_DIGITS=1: index is constant 0 and every tick is a frame boundary.

Decomposition:
- Shared package seven_seg_pkg: 7-bit segment pattern constants SEG_0..SEG_F, SEG_BLANK, and segment bit-index constants.
- One sub-module, seven_seg_nibble_decode: combinational nibble->pattern with HEX_EN parameter, instantiated once on the muxed nibble.
- Prescaler, index, buffering, blanking and polarity stay in the top module.

Test Plan:
- Reset: hold i_Rst_L=0 mid-scan with SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 -> o_Segments=7'h7F, o_Digit_En=4'hF within the same cycle; o_Frame_Pulse=0.
- Scan: NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYCLES=2; load 16'h1234 -> after the next boundary, slots show digit0=0110011 with En=0001, digit1=1111001 with 0010, digit2=1101101 with 0100, digit3=0110000 with 1000. Each slot has 2 cycles all-off followed by 6 cycles lit. o_Frame_Pulse recurs every 32 cycles.
- Tear-free load: load 16'hABCD while digit 2 is active -> current frame still shows 1234; next frame shows d,C,b,A. Loading 16'h1111 then 16'h2222 within one frame -> next frame shows 2222 only.
- Boundary collision: assert i_Load with 16'h0042 on the boundary tick cycle -> the frame starting there shows 0042.
- Blanking: i_Blank_Lz=1, value 16'h0042 -> digits 3,2 unlit, digits 1,0 show 4,2. Value 16'h0000 -> only digit 0 shows 1111110. Value 16'h0400 -> digit 1 shows 0 (not leading).
- HEX_EN=0: value 16'h00F9 -> digit 1 unlit, digit 0 = 1111011.
